// File: rtl/fp_subnorm_shift_arbiter.sv
// rtl/fp_subnorm_shift_arbiter.sv - round-robin shared subnormal right-shifter with registered output stage
module fp_subnorm_shift_arbiter #(
  parameter int MANT_BITS    = 24,
  parameter int EXP_EXT_BITS = 10,
  parameter int TAG_BITS     = 5
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_flush,
  input  logic [1:0]                i_req_valid,
  output logic [1:0]                o_req_ready,
  input  logic [2*MANT_BITS-1:0]    i_req_mantissa,
  input  logic [5:0]                i_req_grs,
  input  logic [2*EXP_EXT_BITS-1:0] i_req_exponent,
  input  logic [2*TAG_BITS-1:0]     i_req_tag,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [MANT_BITS-1:0]      o_mantissa,
  output logic                      o_guard,
  output logic                      o_round,
  output logic                      o_sticky,
  output logic [EXP_EXT_BITS-1:0]   o_exponent,
  output logic [TAG_BITS-1:0]       o_tag,
  output logic                      o_src
);

  localparam int VEC_BITS = MANT_BITS + 3;
  localparam int SH_BITS  = $clog2(VEC_BITS + 1);
  localparam logic signed [EXP_EXT_BITS:0] EXT_ONE = 1;
  localparam logic signed [EXP_EXT_BITS:0] EXT_VEC = VEC_BITS;

  logic out_valid;
  logic prio;
  logic can_accept;
  logic gnt0, gnt1, grant, gnt_idx;

  assign can_accept = !i_flush && (!out_valid || i_ready);

  // Reset also blocks grants so a requester is never acknowledged into a dropped entry.
  always_comb begin
    gnt0 = can_accept && !i_rst && i_req_valid[0] && (!prio || !i_req_valid[1]);
    gnt1 = can_accept && !i_rst && i_req_valid[1] && ( prio || !i_req_valid[0]);
  end

  assign o_req_ready = {gnt1, gnt0};
  assign grant       = gnt0 || gnt1;
  assign gnt_idx     = gnt1;

  logic [MANT_BITS-1:0]           sel_mant;
  logic [2:0]                     sel_grs;
  logic signed [EXP_EXT_BITS-1:0] sel_exp;
  logic [TAG_BITS-1:0]            sel_tag;

  always_comb begin
    sel_mant = gnt_idx ? i_req_mantissa[2*MANT_BITS-1:MANT_BITS] : i_req_mantissa[MANT_BITS-1:0];
    sel_grs  = gnt_idx ? i_req_grs[5:3] : i_req_grs[2:0];
    sel_exp  = gnt_idx ? i_req_exponent[2*EXP_EXT_BITS-1:EXP_EXT_BITS]
                       : i_req_exponent[EXP_EXT_BITS-1:0];
    sel_tag  = gnt_idx ? i_req_tag[2*TAG_BITS-1:TAG_BITS] : i_req_tag[TAG_BITS-1:0];
  end

  logic                           is_sub;
  logic signed [EXP_EXT_BITS:0]   exp_wide;
  logic signed [EXP_EXT_BITS:0]   shift_full;
  logic [SH_BITS-1:0]             sh_amt;
  logic [VEC_BITS-1:0]            vec, shifted, lost_mask;
  logic                           lost;
  logic [MANT_BITS-1:0]           res_mant;
  logic                           res_g, res_r, res_s;
  logic [EXP_EXT_BITS-1:0]        res_exp;

  // One extra bit keeps 1 - exp exact for the most negative exponent.
  always_comb begin
    is_sub     = (sel_exp <= 0);
    exp_wide   = {sel_exp[EXP_EXT_BITS-1], sel_exp};
    shift_full = EXT_ONE - exp_wide;
    sh_amt     = (shift_full > EXT_VEC) ? SH_BITS'(VEC_BITS) : shift_full[SH_BITS-1:0];
    vec        = {sel_mant, sel_grs};
    shifted    = vec >> sh_amt;
    lost_mask  = ~({VEC_BITS{1'b1}} << sh_amt);
    lost       = |(vec & lost_mask);
    if (is_sub) begin
      res_mant = shifted[VEC_BITS-1:3];
      res_g    = shifted[2];
      res_r    = shifted[1];
      res_s    = shifted[0] || lost;
      res_exp  = '0;
    end else begin
      res_mant = sel_mant;
      res_g    = sel_grs[2];
      res_r    = sel_grs[1];
      res_s    = sel_grs[0];
      res_exp  = sel_exp;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_valid  <= 1'b0;
      prio       <= 1'b0;
      o_mantissa <= '0;
      o_guard    <= 1'b0;
      o_round    <= 1'b0;
      o_sticky   <= 1'b0;
      o_exponent <= '0;
      o_tag      <= '0;
      o_src      <= 1'b0;
    end else if (i_flush) begin
      out_valid <= 1'b0;
    end else if (grant) begin
      out_valid  <= 1'b1;
      prio       <= ~gnt_idx;
      o_mantissa <= res_mant;
      o_guard    <= res_g;
      o_round    <= res_r;
      o_sticky   <= res_s;
      o_exponent <= res_exp;
      o_tag      <= sel_tag;
      o_src      <= gnt_idx;
    end else if (i_ready && out_valid) begin
      out_valid <= 1'b0;
    end
  end

  assign o_valid = out_valid;

endmodule

// File: tb/tb_fp_subnorm_shift_arbiter.sv
// tb/tb_fp_subnorm_shift_arbiter.sv - scoreboard bench for fp_subnorm_shift_arbiter
module tb_fp_subnorm_shift_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_flush = 1'b0;
  logic [1:0]  i_req_valid = 2'b00;
  logic [1:0]  o_req_ready;
  logic [47:0] i_req_mantissa = '0;
  logic [5:0]  i_req_grs = '0;
  logic [19:0] i_req_exponent = '0;
  logic [9:0]  i_req_tag = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [23:0] o_mantissa;
  logic        o_guard, o_round, o_sticky;
  logic [9:0]  o_exponent;
  logic [4:0]  o_tag;
  logic        o_src;

  fp_subnorm_shift_arbiter dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_mantissa(i_req_mantissa), .i_req_grs(i_req_grs),
    .i_req_exponent(i_req_exponent), .i_req_tag(i_req_tag),
    .o_valid(o_valid), .i_ready(i_ready),
    .o_mantissa(o_mantissa), .o_guard(o_guard), .o_round(o_round), .o_sticky(o_sticky),
    .o_exponent(o_exponent), .o_tag(o_tag), .o_src(o_src)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [23:0] mant;
    logic [2:0]  grs;
    logic [9:0]  exp;
    logic [4:0]  tag;
    logic [23:0] emant;
    logic [2:0]  egrs;
    logic [9:0]  eexp;
  } vec_t;

  typedef struct {
    vec_t v;
    logic src;
  } sb_t;

  vec_t q0[$];
  vec_t q1[$];
  sb_t  sb[$];
  int   tests = 0;
  int   fails = 0;
  logic ctl_rst = 1'b1, ctl_flush = 1'b0, ctl_ready = 1'b0;

  function automatic vec_t mk(input logic [23:0] mant, input logic [2:0] grs, input int exp,
                              input int tag, input logic [23:0] emant, input logic [2:0] egrs,
                              input int eexp);
    vec_t v;
    v.mant = mant; v.grs = grs; v.exp = 10'(exp); v.tag = 5'(tag);
    v.emant = emant; v.egrs = egrs; v.eexp = 10'(eexp);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample the grant one unit before the rising edge.
  task automatic step(input bit chk, input logic [1:0] exp_rdy);
    logic [1:0] rdy;
    sb_t e;
    @(negedge i_clk);
    i_rst = ctl_rst; i_flush = ctl_flush; i_ready = ctl_ready;
    i_req_valid = {q1.size() > 0, q0.size() > 0};
    if (q0.size() > 0) begin
      i_req_mantissa[23:0] = q0[0].mant; i_req_grs[2:0] = q0[0].grs;
      i_req_exponent[9:0] = q0[0].exp;   i_req_tag[4:0] = q0[0].tag;
    end
    if (q1.size() > 0) begin
      i_req_mantissa[47:24] = q1[0].mant; i_req_grs[5:3] = q1[0].grs;
      i_req_exponent[19:10] = q1[0].exp;  i_req_tag[9:5] = q1[0].tag;
    end
    #4;
    rdy = o_req_ready;
    if (chk) check("req_ready", 32'(rdy), 32'(exp_rdy));
    if (rdy[0] && q0.size() > 0) begin e.v = q0.pop_front(); e.src = 1'b0; sb.push_back(e); end
    if (rdy[1] && q1.size() > 0) begin e.v = q1.pop_front(); e.src = 1'b1; sb.push_back(e); end
  endtask

  always @(negedge i_clk) begin
    sb_t e;
    #2;
    if (i_rst) begin
      sb.delete();
    end else if (o_valid && i_flush) begin
      if (sb.size() > 0) e = sb.pop_front();
    end else if (o_valid && i_ready) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_output: got tag 0x%0h required no output", o_tag);
      end else begin
        e = sb.pop_front();
        check("out_mantissa", 32'(o_mantissa), 32'(e.v.emant));
        check("out_grs", 32'({o_guard, o_round, o_sticky}), 32'(e.v.egrs));
        check("out_exponent", 32'(o_exponent), 32'(e.v.eexp));
        check("out_tag", 32'(o_tag), 32'(e.v.tag));
        check("out_src", 32'(o_src), 32'(e.src));
      end
    end
  end

  task automatic check_cleared(input string pfx);
    check({pfx, "_valid"}, 32'(o_valid), 0);
    check({pfx, "_mantissa"}, 32'(o_mantissa), 0);
    check({pfx, "_grs"}, 32'({o_guard, o_round, o_sticky}), 0);
    check({pfx, "_exponent"}, 32'(o_exponent), 0);
    check({pfx, "_tag"}, 32'(o_tag), 0);
    check({pfx, "_src"}, 32'(o_src), 0);
  endtask

  initial begin
    // Reset state
    ctl_rst = 1'b1;
    step(1, 2'b00);
    step(1, 2'b00);
    check_cleared("reset");
    ctl_rst = 1'b0; ctl_ready = 1'b1;

    // Requester 0 alone, 1-cycle latency
    q0.push_back(mk(24'h800000, 3'b000, -2, 1, 24'h100000, 3'b000, 0));
    step(1, 2'b01);
    step(1, 2'b00);
    check("lat_valid", 32'(o_valid), 1);
    check("lat_src", 32'(o_src), 0);

    // Requester 1 alone: saturated shift, then pass-through
    q1.push_back(mk(24'h000001, 3'b000, -40, 2, 24'h000000, 3'b001, 0));
    step(1, 2'b10);
    q1.push_back(mk(24'hC00000, 3'b101, 5, 3, 24'hC00000, 3'b101, 5));
    step(1, 2'b10);
    step(1, 2'b00);

    // Both requesters valid: strict alternation starting at requester 0
    q0.push_back(mk(24'hABCDEF, 3'b010, 1, 4, 24'hABCDEF, 3'b010, 1));
    q0.push_back(mk(24'h800001, 3'b000, 0, 5, 24'h400000, 3'b100, 0));
    q0.push_back(mk(24'hFFFFFF, 3'b000, -23, 6, 24'h000000, 3'b111, 0));
    q1.push_back(mk(24'h123456, 3'b000, 3, 7, 24'h123456, 3'b000, 3));
    q1.push_back(mk(24'h000008, 3'b001, -1, 8, 24'h000002, 3'b001, 0));
    q1.push_back(mk(24'h400000, 3'b000, -26, 9, 24'h000000, 3'b001, 0));
    for (int i = 0; i < 6; i++) step(1, (i % 2 == 0) ? 2'b01 : 2'b10);
    step(1, 2'b00);

    // Stall with both valid, then release with no bubble
    ctl_ready = 1'b0;
    q0.push_back(mk(24'h000010, 3'b000, -512, 10, 24'h000000, 3'b001, 0));
    q0.push_back(mk(24'h000003, 3'b011, 0, 11, 24'h000001, 3'b101, 0));
    q1.push_back(mk(24'h7FFFFF, 3'b110, 10, 12, 24'h7FFFFF, 3'b110, 10));
    step(1, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00);
      check("stall_valid", 32'(o_valid), 1);
      check("stall_tag", 32'(o_tag), 10);
      check("stall_sticky", 32'(o_sticky), 1);
    end
    ctl_ready = 1'b1;
    step(1, 2'b10);
    check("release_tag", 32'(o_tag), 10);
    step(1, 2'b01);
    check("nobubble_valid", 32'(o_valid), 1);
    check("nobubble_src", 32'(o_src), 1);
    step(1, 2'b00);

    // Flush discards the shown result and blocks the grant for one cycle
    q0.push_back(mk(24'h000100, 3'b000, -8, 13, 24'h000000, 3'b100, 0));
    step(1, 2'b01);
    q0.push_back(mk(24'h555555, 3'b011, 511, 14, 24'h555555, 3'b011, 511));
    ctl_flush = 1'b1;
    step(1, 2'b00);
    ctl_flush = 1'b0;
    step(1, 2'b01);
    check("flush_valid", 32'(o_valid), 0);
    step(1, 2'b00);

    // Reset while stalled drops the entry and restores priority to requester 0
    ctl_ready = 1'b0;
    q0.push_back(mk(24'h000002, 3'b000, -1, 15, 24'h000000, 3'b100, 0));
    step(1, 2'b01);
    q0.push_back(mk(24'h800000, 3'b001, 0, 16, 24'h400000, 3'b001, 0));
    q1.push_back(mk(24'h0000FF, 3'b000, 2, 17, 24'h0000FF, 3'b000, 2));
    step(1, 2'b00);
    check("prereset_valid", 32'(o_valid), 1);
    ctl_rst = 1'b1;
    step(1, 2'b00);
    step(1, 2'b00);
    check_cleared("midreset");
    ctl_rst = 1'b0; ctl_ready = 1'b1;
    step(1, 2'b01);
    step(1, 2'b10);
    for (int i = 0; i < 3; i++) step(1, 2'b00);

    check("sb_drained", 32'(sb.size()), 0);
    check("req_drained", 32'(q0.size() + q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
